cop0_reader: RTL and testbench
==============================

Name: cop0_reader

Overview:
- Read side of the CP0 access path. Services mfc0 reads issued in stage execute.
- Tracks CP0 writes that have left execute but are not yet committed to the CP0 register file: mtc0 data and implicit Status updates.
- Returns the architecturally current value: the youngest in-flight write wins, otherwise the register-file value.
- Result is registered and goes to stage memory with a one-cycle latency.

Parameters:
- INFLIGHT, 2, number of shadow write stages between execute and CP0 commit; legal 1..3.
- DW, 32, CP0 register data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall; holds all shadow stages and blocks read acceptance.
- flush  input  1  kills the execute-stage instruction: drops any incoming read or write this cycle.
- rd_en  input  1  mfc0 present in execute.
- rd  input  5  CP0 register number to read.
- sel  input  3  CP0 select field to read.
- rf_rdata  input  DW  combinational CP0 register-file data for {rd,sel}.
- wr_en  input  1  CP0 write leaving execute this cycle.
- wr_rd  input  5  register number of the write.
- wr_sel  input  3  select field of the write.
- wr_data  input  DW  write value, already filtered and muxed upstream.
- dout  output  DW  read result.
- dout_valid  output  1  one-cycle pulse; dout is valid.
- hazard  output  1  read cannot be serviced this cycle; requests a stall (forwarding-disabled builds only).

Behaviour:
- Reset (async): all shadow valid bits 0; dout = 0; dout_valid = 0; hazard = 0. Shadow data/tag contents are don't-care.
- Shadow pipe: entries S[0] (youngest) .. S[INFLIGHT-1] (oldest). Each entry holds {valid, rd, sel, data}.
- Each clk edge with stall = 0:
  - S[0] <= {wr_en & ~flush, wr_rd, wr_sel, wr_data}.
  - S[i] <= S[i-1] for i > 0.
  - The old S[INFLIGHT-1] retires; the register file commits it the same edge, outside this block.
- stall = 1: all entries hold.
- flush affects only the incoming write. Entries already in the shadow pipe are older than the flushing instruction and are never cleared.
- Read acceptance: rd_en & ~stall & ~flush & ~hazard.
- Read source, evaluated combinationally in the accept cycle:
  - Match = entry valid and {rd,sel} == {entry.rd, entry.sel}.
  - Lowest-index matching entry wins; if no entry matches, source is rf_rdata.
  - A coincident incoming wr_en is never a source: mfc0 and mtc0 are exclusive, so a write in the same cycle belongs to a different instruction.
- Output timing:
  - Accepted read at edge t: dout <= source at t, and dout_valid = 1 during cycle t+1.
  - No accepted read: dout_valid <= 0 and dout holds its last value.
- Unimplemented {rd,sel} (outside the implemented set in cop0_info): source is forced to 0, even when a shadow entry matches.
- Simultaneous retire and read hit on S[INFLIGHT-1]: the forwarded value equals the committing value, so the result is correct either way.
- Reset mid-read: dout_valid drops immediately and the pending result is lost.

Optional Feature:
- COP0_READER_BYPASS_EN defined:
  - Forwarding as described above.
  - hazard is tied to 0.
- COP0_READER_BYPASS_EN undefined:
  - No forwarding; source is always rf_rdata, or 0 for unimplemented registers.
  - hazard = rd_en & ~flush & (any valid entry matches {rd,sel}), combinational.
  - The read is not accepted while hazard = 1. Upstream stalls execute while the shadow pipe drains.
  - Shadow entries advance during hazard even if stall = 1. Rationale: stall is asserted because of hazard, and advancing prevents deadlock.

Decomposition:
- cop0_info package additions:
  - CP0 key type {rd[4:0], sel[2:0]}.
  - Shadow entry struct {valid, key, data}.
  - Implemented-register predicate function.
  - Default INFLIGHT constant.
- Sub-module cop0_shadow_stage: one registered entry with enable and async reset of valid. It is instantiated INFLIGHT times via generate.
- Match/priority logic stays in cop0_reader.

Test Plan:
- Reset, then read Status (12,0) with rf_rdata = 0x0040_FF01 and no writes -> next cycle dout = 0x0040_FF01, dout_valid = 1 for exactly one cycle.
- mtc0 EPC (14,0) = 0xBFC0_0180 at cycle 0, then mfc0 EPC at cycle 1 with rf_rdata = 0x0 -> bypass build: dout = 0xBFC0_0180 at cycle 2; non-bypass build: hazard = 1 for INFLIGHT cycles, then dout = rf_rdata.
- Two writes to Compare (11,0), 0x10 then 0x20, then a read while both are in flight -> dout = 0x20 (youngest wins).
- mtc0 Status with flush = 1 in the same cycle, then read Status -> shadow not loaded; dout = rf_rdata.
- stall = 1 for 3 cycles with rd_en = 1 and one entry in flight -> no dout_valid and entries hold; on release, one pulse with the forwarded data.
- Read of unimplemented (7,5) while an entry matches with 0xDEAD_BEEF -> dout = 0. Assert reset mid-cycle after acceptance -> dout_valid = 0 and dout = 0 asynchronously.

Source files
------------

// File: rtl/cop0_info_pkg.sv
// ---------------------------------------------------------------------------
// cop0_info: shared CP0 types and helpers for the CP0 read path.
//   cp0_key_t       {rd, sel} register address
//   shadow_entry_t  one in-flight CP0 write {valid, key, data}
//   cp0_implemented which {rd, sel} pairs exist in this core's CP0
//   DEFAULT_INFLIGHT default depth of the shadow write pipe
// ---------------------------------------------------------------------------
package cop0_info;

  localparam int DEFAULT_INFLIGHT = 2;
  localparam int CP0_DW           = 32;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] sel;
  } cp0_key_t;

  typedef struct packed {
    logic              valid;
    cp0_key_t          key;
    logic [CP0_DW-1:0] data;
  } shadow_entry_t;

  // Implemented set: sel 0 for Index..Config except HWREna (7),
  // plus EBase (15,1) and Config1 (16,1).
  function automatic logic cp0_implemented(cp0_key_t k);
    logic ok;
    ok = 1'b0;
    case (k.sel)
      3'd0:    ok = (k.rd <= 5'd16) && (k.rd != 5'd7);
      3'd1:    ok = (k.rd == 5'd15) || (k.rd == 5'd16);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cop0_reader_shadow_stage.sv
// ---------------------------------------------------------------------------
// cop0_shadow_stage: one register slot of the CP0 shadow write pipe.
//   clk    system clock
//   reset  async active-high reset, clears valid only
//   en     load d into the slot on this edge
//   d      incoming entry
//   q      held entry
// ---------------------------------------------------------------------------
module cop0_shadow_stage
  import cop0_info::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  logic              valid_q;
  cp0_key_t          key_q;
  logic [CP0_DW-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   valid_q <= 1'b0;
    else if (en) valid_q <= d.valid;
  end

  // NOTE: tag and data carry no reset; valid alone qualifies them, so the
  // payload flops stay plain enable flops.
  always_ff @(posedge clk) begin
    if (en) begin
      key_q  <= d.key;
      data_q <= d.data;
    end
  end

  assign q = '{valid: valid_q, key: key_q, data: data_q};

endmodule

// File: rtl/cop0_reader.sv
// ---------------------------------------------------------------------------
// cop0_reader: read side of the CP0 access path (mfc0 in execute).
// Tracks CP0 writes that have left execute but not yet committed, and returns
// the architecturally current value with a one-cycle registered latency.
//
// Build option: COP0_READER_BYPASS_EN
//   defined   - in-flight writes are forwarded, hazard tied to 0
//   undefined - no forwarding; a read that hits an in-flight write raises
//               hazard and waits for the shadow pipe to drain
//
// Ports:
//   clk, reset          clock, async active-high reset
//   stall               holds shadow pipe, blocks read acceptance
//   flush               kills the execute instruction (read or write)
//   rd_en, rd, sel      mfc0 request in execute
//   rf_rdata            CP0 register-file data for {rd, sel}
//   wr_en, wr_rd,
//   wr_sel, wr_data     CP0 write leaving execute
//   dout, dout_valid    registered read result and its one-cycle strobe
//   hazard              read blocked, upstream must stall
//
// DW must equal cop0_info::CP0_DW (the shadow entry data width).
// ---------------------------------------------------------------------------
module cop0_reader
  import cop0_info::*;
#(
  parameter int INFLIGHT = DEFAULT_INFLIGHT,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          rd_en,
  input  logic [4:0]    rd,
  input  logic [2:0]    sel,
  input  logic [DW-1:0] rf_rdata,
  input  logic          wr_en,
  input  logic [4:0]    wr_rd,
  input  logic [2:0]    wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          hazard
);

  shadow_entry_t stage_d [INFLIGHT];
  shadow_entry_t stage_q [INFLIGHT];
  cp0_key_t      rd_key;
  logic          shift_en;
  logic          any_match;
  logic          accept;
  logic [DW-1:0] source;

  assign rd_key = {rd, sel};

  // A flushed write never enters the pipe; older entries are untouched.
  assign stage_d[0] = '{valid: wr_en & ~flush, key: {wr_rd, wr_sel}, data: wr_data};

  for (genvar i = 1; i < INFLIGHT; i++) begin : g_chain
    assign stage_d[i] = stage_q[i-1];
  end

  for (genvar i = 0; i < INFLIGHT; i++) begin : g_stage
    cop0_shadow_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .d     (stage_d[i]),
      .q     (stage_q[i])
    );
  end

`ifdef COP0_READER_BYPASS_EN
  logic [DW-1:0] fwd_data;
`endif

  // Scan oldest to youngest so the last hit (lowest index, youngest) wins.
  always_comb begin
    any_match = 1'b0;
`ifdef COP0_READER_BYPASS_EN
    fwd_data  = '0;
`endif
    for (int i = INFLIGHT - 1; i >= 0; i--) begin
      if (stage_q[i].valid && (stage_q[i].key == rd_key)) begin
        any_match = 1'b1;
`ifdef COP0_READER_BYPASS_EN
        fwd_data  = stage_q[i].data;
`endif
      end
    end
  end

`ifdef COP0_READER_BYPASS_EN
  assign hazard   = 1'b0;
  assign shift_en = ~stall;
`else
  assign hazard   = rd_en & ~flush & any_match;
  // The pipe keeps draining while hazard holds execute, otherwise the stall
  // that hazard itself causes would freeze the entry it waits on.
  assign shift_en = ~stall | hazard;
`endif

  assign accept = rd_en & ~stall & ~flush & ~hazard;

  always_comb begin
    source = rf_rdata;
    if (!cp0_implemented(rd_key)) begin
      source = '0;
    end
`ifdef COP0_READER_BYPASS_EN
    else if (any_match) begin
      source = fwd_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= accept;
      if (accept) dout <= source;
    end
  end

endmodule

// File: tb/tb_cop0_reader.sv
// ---------------------------------------------------------------------------
// tb_cop0_reader: self-checking bench for cop0_reader.
// A behavioural model keeps the in-flight CP0 writes as a youngest-first list
// and answers each read from the architectural rules. Directed scenarios are
// followed by a randomized phase. Follows COP0_READER_BYPASS_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_cop0_reader;

  localparam int N = 2;
`ifdef COP0_READER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, rd_en, wr_en;
  logic [4:0]  rd, wr_rd;
  logic [2:0]  sel, wr_sel;
  logic [31:0] rf_rdata, wr_data, dout;
  logic        dout_valid, hazard;

  always #5 clk = ~clk;

  cop0_reader #(.INFLIGHT(N), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd         (rd),
    .sel        (sel),
    .rf_rdata   (rf_rdata),
    .wr_en      (wr_en),
    .wr_rd      (wr_rd),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .hazard     (hazard)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight writes, index 0 = youngest.
  bit        m_valid [N];
  bit [7:0]  m_key   [N];
  bit [31:0] m_data  [N];
  bit [31:0] exp_dout;
  bit        exp_valid;

  function automatic bit impl(bit [4:0] r, bit [2:0] s);
    if (s == 3'd0) return r inside {0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    if (s == 3'd1) return r inside {15, 16};
    return 1'b0;
  endfunction

  task automatic model_lookup(input bit [7:0] key, output bit found, output bit [31:0] data);
    found = 1'b0;
    data  = 32'h0;
    for (int i = 0; i < N; i++) begin
      if (!found && m_valid[i] && m_key[i] == key) begin
        found = 1'b1;
        data  = m_data[i];
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    exp_dout  = 32'h0;
    exp_valid = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check hazard, check registered
  // outputs just after the rising edge. i_auto makes upstream stall on hazard.
  task automatic cycle(input bit i_stall, input bit i_auto, input bit i_flush,
                       input bit i_rd_en, input bit [4:0] i_rd, input bit [2:0] i_sel,
                       input bit [31:0] i_rf, input bit i_wr_en, input bit [4:0] i_wr_rd,
                       input bit [2:0] i_wr_sel, input bit [31:0] i_wr_data,
                       output bit o_hz, output bit o_valid);
    bit        found, ehz, acc;
    bit [31:0] fdata, src;
    @(negedge clk);
    flush = i_flush; rd_en = i_rd_en; rd = i_rd; sel = i_sel; rf_rdata = i_rf;
    wr_en = i_wr_en; wr_rd = i_wr_rd; wr_sel = i_wr_sel; wr_data = i_wr_data;
    model_lookup({i_rd, i_sel}, found, fdata);
    ehz   = !BYPASS && i_rd_en && !i_flush && found;
    stall = i_stall | (i_auto & ehz);
    #1;
    check("hazard", hazard, ehz);
    o_hz = hazard;
    @(posedge clk);
    acc = i_rd_en && !stall && !i_flush && !ehz;
    if (!impl(i_rd, i_sel))     src = 32'h0;
    else if (BYPASS && found)   src = fdata;
    else                        src = i_rf;
    exp_valid = acc;
    if (acc) exp_dout = src;
    if (!stall || ehz) begin
      for (int i = N - 1; i > 0; i--) begin
        m_valid[i] = m_valid[i-1]; m_key[i] = m_key[i-1]; m_data[i] = m_data[i-1];
      end
      m_valid[0] = i_wr_en && !i_flush;
      m_key[0]   = {i_wr_rd, i_wr_sel};
      m_data[0]  = i_wr_data;
    end
    #1;
    check("dout_valid", dout_valid, exp_valid);
    check("dout", dout, exp_dout);
    o_valid = dout_valid;
  endtask

  task automatic idle();
    bit h, v;
    cycle(0, 0, 0, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 3'd0, 32'h0, h, v);
  endtask

  task automatic write(input bit [4:0] r, input bit [2:0] s, input bit [31:0] d, input bit fl);
    bit h, v;
    cycle(0, 0, fl, 0, 5'd0, 3'd0, 32'h0, 1, r, s, d, h, v);
  endtask

  // Issue a read, stalling upstream on hazard, until the result strobes.
  task automatic read_until(input bit [4:0] r, input bit [2:0] s, input bit [31:0] rf,
                            output int hz_cnt);
    bit h, v, got;
    hz_cnt = 0;
    got    = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle(0, 1, 0, 1, r, s, rf, 0, 5'd0, 3'd0, 32'h0, h, v);
      if (h) hz_cnt++;
      got = v;
    end
    check("read_done", got, 1'b1);
  endtask

  initial begin
    int hz;
    bit h, v;
    reset = 1'b1; stall = 0; flush = 0; rd_en = 0; wr_en = 0;
    rd = 0; sel = 0; wr_rd = 0; wr_sel = 0; rf_rdata = 0; wr_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 32'h0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_hazard", hazard, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Plain read of Status, then one idle to see the strobe fall.
    cycle(0, 0, 0, 1, 5'd12, 3'd0, 32'h0040_FF01, 0, 5'd0, 3'd0, 32'h0, h, v);
    check("t1_dout", dout, 32'h0040_FF01);
    idle();
    check("t1_pulse_end", dout_valid, 1'b0);

    // Write EPC then read it immediately.
    write(5'd14, 3'd0, 32'hBFC0_0180, 0);
    read_until(5'd14, 3'd0, 32'h0, hz);
    check("t2_hz_cycles", hz, BYPASS ? 0 : N);
    check("t2_dout", dout, BYPASS ? 32'hBFC0_0180 : 32'h0);
    idle(); idle();

    // Two writes to Compare, youngest must win.
    write(5'd11, 3'd0, 32'h10, 0);
    write(5'd11, 3'd0, 32'h20, 0);
    read_until(5'd11, 3'd0, 32'h20, hz);
    check("t3_dout", dout, 32'h20);
    idle(); idle();

    // Flushed write to Status never enters the shadow pipe.
    write(5'd12, 3'd0, 32'hFFFF_FFFF, 1);
    read_until(5'd12, 3'd0, 32'h1234, hz);
    check("t4_hz_cycles", hz, 0);
    check("t4_dout", dout, 32'h1234);
    idle(); idle();

    // Read held off by stall with one entry in flight.
    write(5'd14, 3'd0, 32'h8000_0040, 0);
    for (int k = 0; k < 3; k++)
      cycle(1, 0, 0, 1, 5'd14, 3'd0, 32'h8000_0040, 0, 5'd0, 3'd0, 32'h0, h, v);
    read_until(5'd14, 3'd0, 32'h8000_0040, hz);
    check("t5_dout", dout, 32'h8000_0040);
    idle(); idle();

    // Unimplemented register reads as zero even with a matching entry.
    write(5'd7, 3'd5, 32'hDEAD_BEEF, 0);
    read_until(5'd7, 3'd5, 32'h5555_5555, hz);
    check("t6_dout", dout, 32'h0);

    // Reset right after an accepted read: strobe and data clear at once.
    read_until(5'd12, 3'd0, 32'hCAFE_0001, hz);
    #1 reset = 1'b1;
    #1;
    check("t7_valid", dout_valid, 1'b0);
    check("t7_dout", dout, 32'h0);
    model_reset();
    #1 reset = 1'b0;
    idle();

    // Randomized traffic over a small register set to provoke matches.
    for (int k = 0; k < 600; k++) begin
      bit        r_en, w_en, st, fl, au;
      bit [4:0]  r, wr;
      bit [2:0]  s, ws;
      bit [4:0]  pick [4];
      pick[0] = 5'd11; pick[1] = 5'd12; pick[2] = 5'd14; pick[3] = 5'd7;
      r_en = ($urandom_range(0, 99) < 45);
      w_en = !r_en && ($urandom_range(0, 99) < 50);
      st   = ($urandom_range(0, 99) < 20);
      fl   = ($urandom_range(0, 99) < 10);
      au   = ($urandom_range(0, 99) < 70);
      r    = pick[$urandom_range(0, 3)];
      wr   = pick[$urandom_range(0, 3)];
      s    = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'd0;
      ws   = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'd0;
      cycle(st, au, fl, r_en, r, s, $urandom, w_en, wr, ws, $urandom, h, v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
